// File: rtl/mux_arb_n_1.sv
//============================================================================
// Module  : mux_arb_n_1
// Brief   : N-input valid/ready mux/arbiter (fixed, priority, round-robin)
//           feeding a one-entry registered output with channel index.
// Rev     : 1.0 - initial release
//============================================================================
`default_nettype none

module mux_arb_n_1 #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [1:0]       mode,
    input  logic [SW-1:0]    sel,
    output logic [W-1:0]     out_data,
    output logic [SW-1:0]    out_ch,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [1:0] c_MODE_FIXED = 2'b00;
    localparam logic [1:0] c_MODE_RR    = 2'b10;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_out_data;
    logic [SW-1:0]   r_out_ch;
    logic [SW-1:0]   r_rr_ptr;

    logic            w_load_en;
    logic            w_grant_vld;
    logic [SW-1:0]   w_grant_idx;
    logic            w_xfer;
    logic [W-1:0]    w_sel_data;
    logic [N-1:0]    w_rot;
    logic [SW:0]     w_sum;
    logic [SW-1:0]   w_rr_nxt;

    assign out_valid = (r_state == FULL);
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign w_load_en = !out_valid || out_ready;

    // Valid vector rotated so bit 0 is the channel at the round-robin pointer
    assign w_rot = N'({in_valid, in_valid} >> r_rr_ptr);

    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_sum       = '0;
        case (mode)
            c_MODE_FIXED: begin
                for (int i = 0; i < N; i++) begin
                    if (sel == SW'(i) && in_valid[i]) begin
                        w_grant_vld = 1'b1;
                        w_grant_idx = SW'(i);
                    end
                end
            end
            c_MODE_RR: begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (w_rot[i]) begin
                        w_grant_vld = 1'b1;
                        w_sum       = {1'b0, r_rr_ptr} + (SW+1)'(i);
                        w_grant_idx = (w_sum >= (SW+1)'(N)) ? SW'(w_sum - (SW+1)'(N))
                                                             : SW'(w_sum);
                    end
                end
            end
            default: begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (in_valid[i]) begin
                        w_grant_vld = 1'b1;
                        w_grant_idx = SW'(i);
                    end
                end
            end
        endcase
    end

    assign w_xfer = w_grant_vld && w_load_en;

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant_idx == SW'(i)) begin
                w_sel_data = in_data[i*W +: W];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ready
            assign in_ready[gi] = rst_n && w_xfer && (w_grant_idx == SW'(gi));
        end
    endgenerate

    assign w_rr_nxt = (w_grant_idx == SW'(N - 1)) ? '0 : w_grant_idx + SW'(1);

    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer) begin
            w_state_nxt = FULL;
        end else if (w_load_en) begin
            w_state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_out_data <= '0;
            r_out_ch   <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_out_data <= w_sel_data;
                r_out_ch   <= w_grant_idx;
                if (mode == c_MODE_RR) begin
                    r_rr_ptr <= w_rr_nxt;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mux_arb_n_1.sv
//============================================================================
// Module  : tb_mux_arb_n_1
// Brief   : Self-checking bench for mux_arb_n_1 (N=4, W=8).
// Rev     : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_mux_arb_n_1;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [1:0]      mode;
    logic [SW-1:0]   sel;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_ch;
    logic            out_valid;
    logic            out_ready;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic            m_valid;
    logic [W-1:0]    m_data;
    int              m_ch;
    int              m_rr;

    mux_arb_n_1 #(.N(N), .W(W), .SW(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Grant chosen by the rules: fixed index, lowest index, or nearest
    // requester at or after the pointer going around the ring.
    task automatic ref_grant(input logic [1:0] md, input int sl, input logic [N-1:0] v,
                             input int rr, output bit ok, output int idx);
        int best_d;
        ok = 0; idx = 0; best_d = N;
        if (md == 2'b00) begin
            if (sl < N && v[sl]) begin ok = 1; idx = sl; end
        end else if (md == 2'b10) begin
            for (int i = 0; i < N; i++) begin
                int d;
                d = (i - rr + N) % N;
                if (v[i] && d < best_d) begin best_d = d; idx = i; ok = 1; end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--)
                if (v[i]) begin idx = i; ok = 1; end
        end
    endtask

    // One cycle, entered just after a falling edge; inputs already driven.
    task automatic model_cycle();
        bit ok; int idx; bit ld;
        logic [N-1:0] exp_rdy;
        #1;
        ref_grant(mode, int'(sel), in_valid, m_rr, ok, idx);
        ld = !m_valid || out_ready;
        exp_rdy = (ok && ld) ? N'(1 << idx) : '0;
        chk("rand_in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (ok && ld) begin
            m_valid = 1'b1;
            m_data  = in_data[idx*W +: W];
            m_ch    = idx;
            if (mode == 2'b10) m_rr = (idx + 1) % N;
        end else if (ld) begin
            m_valid = 1'b0;
        end
        #1;
        chk("rand_out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("rand_out_data", 32'(out_data), 32'(m_data));
            chk("rand_out_ch", 32'(out_ch), 32'(m_ch));
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = '1;
        mode      = 2'b01;
        sel       = '0;
        out_ready = 1'b0;
        in_data   = {8'h40, 8'h30, 8'h20, 8'h10};
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n    = 1'b1;
        in_valid = '0;
        m_valid = 1'b0; m_data = '0; m_ch = 0; m_rr = 0;
    endtask

    typedef struct {
        logic [1:0] md;
        logic [1:0] sl;
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
        logic [7:0] od;
        logic [1:0] oc;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{2'd1, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0};
        tbl[1]  = '{2'd0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h30, 2'd2};
        tbl[2]  = '{2'd0, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 8'h30, 2'd2};
        tbl[3]  = '{2'd1, 2'd0, 4'b1010, 1'b0, 4'b0010, 1'b1, 8'h20, 2'd1};
        tbl[4]  = '{2'd1, 2'd0, 4'b1010, 1'b0, 4'b0000, 1'b1, 8'h20, 2'd1};
        tbl[5]  = '{2'd1, 2'd0, 4'b1010, 1'b0, 4'b0000, 1'b1, 8'h20, 2'd1};
        tbl[6]  = '{2'd1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h20, 2'd1};
        tbl[7]  = '{2'd3, 2'd0, 4'b1100, 1'b1, 4'b0100, 1'b1, 8'h30, 2'd2};
        tbl[8]  = '{2'd2, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
        tbl[9]  = '{2'd2, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 8'h40, 2'd3};
        tbl[10] = '{2'd2, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
        tbl[11] = '{2'd0, 2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h20, 2'd1};
        tbl[12] = '{2'd2, 2'd0, 4'b0101, 1'b0, 4'b0000, 1'b1, 8'h20, 2'd1};
        tbl[13] = '{2'd2, 2'd0, 4'b0101, 1'b1, 4'b0100, 1'b1, 8'h30, 2'd2};
        tbl[14] = '{2'd2, 2'd0, 4'b0011, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
        tbl[15] = '{2'd2, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0};

        @(negedge clk);
        do_reset();

        for (int k = 0; k < 16; k++) begin
            mode = tbl[k].md; sel = tbl[k].sl; in_valid = tbl[k].vld; out_ready = tbl[k].ordy;
            #1;
            chk($sformatf("vec%0d_in_ready", k), 32'(in_ready), 32'(tbl[k].rdy));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out_valid", k), 32'(out_valid), 32'(tbl[k].ov));
            chk($sformatf("vec%0d_out_data", k), 32'(out_data), 32'(tbl[k].od));
            chk($sformatf("vec%0d_out_ch", k), 32'(out_ch), 32'(tbl[k].oc));
            @(negedge clk);
        end

        // Round-robin fairness: all requesting, one word per cycle
        do_reset();
        mode = 2'b10; in_valid = '1; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk($sformatf("rr_fair%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("rr_fair%0d_ch", k), 32'(out_ch), 32'(k % N));
        end
        @(negedge clk);

        // Asynchronous reset while holding a word
        mode = 2'b00; sel = 2'd3; in_valid = '1; out_ready = 1'b0;
        @(posedge clk); #1;
        chk("midrst_loaded_data", 32'(out_data), 32'h40);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; mode = 2'b10; in_valid = 4'b1011; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("midrst_rr_restart_ch", 32'(out_ch), 32'd0);
        @(negedge clk);

        // Randomized traffic against the reference model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            mode      = 2'($urandom_range(0, 3));
            sel       = SW'($urandom_range(0, N - 1));
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = ($urandom);
            model_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
